div_iter: RTL

- Iterative radix-2 restoring divider for the M extension, covering DIV, DIVU, REM and REMU.
- It is the inverse-operation counterpart to the multiplier datapath and sits beside it in the M unit.
- It accepts operands on a start pulse, computes one quotient bit per cycle, applies sign and RISC-V special-case fix-up, then returns the result with a one-cycle ready pulse.

---
 rtl/div_iter.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module   : div_iter
// Purpose  : Iterative radix-2 restoring divider for the RISC-V M extension
//            (DIV, DIVU, REM, REMU). One quotient bit is produced per cycle,
//            followed by a single sign / special-case fix-up cycle and a
//            one-cycle ready pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   XLEN    operand / result width (power of two, >= 8), default 32
// Ports
//   CLK     in   1     clock, rising edge
//   RST     in   1     synchronous active-high reset
//   START   in   1     request, sampled only while idle
//   KILL    in   1     flush; aborts an operation in progress
//   OP      in   2     00=DIV 01=DIVU 10=REM 11=REMU
//   RS1     in   XLEN  dividend
//   RS2     in   XLEN  divisor
//   BUSY    out  1     operation in progress (CALC or FIX)
//   RDY     out  1     one-cycle pulse, RESULT valid
//   RESULT  out  XLEN  quotient or remainder, held until next completion
// Build option
//   DIV_FAST_EN  when defined, divide-by-zero and signed overflow skip the
//                iterative phase and go straight to the fix-up cycle.
// ============================================================================
module div_iter #(
   parameter int XLEN = 32
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            START,
   input  logic            KILL,
   input  logic [1:0]      OP,
   input  logic [XLEN-1:0] RS1,
   input  logic [XLEN-1:0] RS2,
   output logic            BUSY,
   output logic            RDY,
   output logic [XLEN-1:0] RESULT
);

   localparam int              CNT_W    = $clog2(XLEN);
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state;
   state_t state_next;

   // -------------------------------------------------------------------------
   // Operand decode in IDLE
   // -------------------------------------------------------------------------
   logic            signed_op;
   logic            rs1_neg;
   logic            rs2_neg;
   logic [XLEN-1:0] rs1_mag;
   logic [XLEN-1:0] rs2_mag;
   logic            div0_in;
   logic            ovf_in;
   logic            accept;

   always_comb begin
      signed_op = ~OP[0];
      rs1_neg   = signed_op & RS1[XLEN-1];
      rs2_neg   = signed_op & RS2[XLEN-1];
      // The most-negative value negates to itself, which is its correct
      // magnitude when read as unsigned.
      rs1_mag   = rs1_neg ? -RS1 : RS1;
      rs2_mag   = rs2_neg ? -RS2 : RS2;
      div0_in   = (RS2 == '0);
      ovf_in    = signed_op && (RS1 == MOST_NEG) && (RS2 == '1);
      accept    = (state == IDLE) && START && !KILL;
   end

   // -------------------------------------------------------------------------
   // Datapath registers
   // -------------------------------------------------------------------------
   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0]  quo;
   logic [XLEN-1:0]  rem;
   logic [XLEN-1:0]  divisor;
   logic [XLEN-1:0]  rs1_orig;
   logic             rem_sel;
   logic             dsign;
   logic             qsign;
   logic             div0;
   logic             ovf;

   // -------------------------------------------------------------------------
   // One restoring step. The shifted partial remainder can need XLEN+1 bits
   // (unsigned divisors above 2^(XLEN-1)), so the trial subtraction is done
   // at that width and its MSB is the borrow.
   // -------------------------------------------------------------------------
   logic [XLEN:0]   shifted;
   logic [XLEN:0]   trial;
   logic            trial_ok;
   logic [XLEN-1:0] rem_step;
   logic [XLEN-1:0] quo_step;

   always_comb begin
      shifted  = {rem, quo[XLEN-1]};
      trial    = shifted - {1'b0, divisor};
      trial_ok = ~trial[XLEN];
      rem_step = trial_ok ? trial[XLEN-1:0] : shifted[XLEN-1:0];
      quo_step = {quo[XLEN-2:0], trial_ok};
   end

   // -------------------------------------------------------------------------
   // Fix-up: restore signs, then apply the architectural special cases,
   // which take priority over whatever the iteration produced.
   // -------------------------------------------------------------------------
   logic [XLEN-1:0] quo_fix;
   logic [XLEN-1:0] rem_fix;
   logic [XLEN-1:0] fix_result;

   always_comb begin
      quo_fix = qsign ? -quo : quo;
      rem_fix = dsign ? -rem : rem;
      if (div0) begin
         quo_fix = '1;
         rem_fix = rs1_orig;
      end else if (ovf) begin
         quo_fix = rs1_orig;
         rem_fix = '0;
      end
      fix_result = rem_sel ? rem_fix : quo_fix;
   end

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next state and outputs
   // -------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      BUSY       = 1'b0;
      RDY        = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
`ifdef DIV_FAST_EN
               state_next = (div0_in || ovf_in) ? FIX : CALC;
`else
               state_next = CALC;
`endif
            end
         end
         CALC: begin
            BUSY = 1'b1;
            if (KILL) begin
               state_next = IDLE;
            end else if (cnt == '0) begin
               state_next = FIX;
            end
         end
         FIX: begin
            BUSY       = 1'b1;
            state_next = KILL ? IDLE : DONE;
         end
         DONE: begin
            // A kill arriving here is too late to suppress the pulse.
            RDY        = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath update
   // -------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt      <= '0;
         quo      <= '0;
         rem      <= '0;
         divisor  <= '0;
         rs1_orig <= '0;
         rem_sel  <= 1'b0;
         dsign    <= 1'b0;
         qsign    <= 1'b0;
         div0     <= 1'b0;
         ovf      <= 1'b0;
         RESULT   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  cnt      <= CNT_W'(XLEN - 1);
                  quo      <= rs1_mag;
                  rem      <= '0;
                  divisor  <= rs2_mag;
                  rs1_orig <= RS1;
                  rem_sel  <= OP[1];
                  dsign    <= rs1_neg;
                  qsign    <= rs1_neg ^ rs2_neg;
                  div0     <= div0_in;
                  ovf      <= ovf_in;
               end
            end
            CALC: begin
               quo <= quo_step;
               rem <= rem_step;
               cnt <= cnt - CNT_W'(1);
            end
            FIX: begin
               // A killed operation leaves the previous result visible.
               if (!KILL) begin
                  RESULT <= fix_result;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire
